int_controller: RTL and testbench

INT_CONTROLLER -- requirements
Module: int_controller

---
 rtl/int_pkg.sv | 32 +++
 rtl/prio_enc.sv | 31 +++
 rtl/int_controller.sv | 182 ++++++++++++++++++
 tb/tb_int_controller.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// ============================================================================
// int_pkg : register offsets, CTRL bit positions and FSM encoding for int_controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package int_pkg;

    localparam int c_off_pending  = 0;
    localparam int c_off_mask     = 1;
    localparam int c_off_ctrl     = 2;
    localparam int c_off_vec_base = 3;
    localparam int c_off_retaddr  = 4;
    localparam int c_n_regs       = 5;

    localparam int c_ctrl_en_bit   = 0;
    localparam int c_ctrl_mode_lsb = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    // A single source still needs a 1-bit id.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prio_enc.sv
// ============================================================================
// prio_enc : fixed-priority encoder, lowest set index wins
// Revision: 1.0
// ============================================================================
`default_nettype none

module prio_enc
    import int_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int ID_W  = id_width(N_SRC)
) (
    input  logic [N_SRC-1:0] req_i,
    output logic [ID_W-1:0]  id_o,
    output logic             valid_o
);

    always_comb begin
        id_o = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o = ID_W'(i);
            end
        end
    end

    assign valid_o = |req_i;

endmodule

`default_nettype wire

// File: rtl/int_controller.sv
// ============================================================================
// int_controller : memory-mapped interrupt controller with edge/level sources
// Revision: 1.0
// ============================================================================
`default_nettype none

module int_controller
    import int_pkg::*;
#(
    parameter int          N_SRC      = 4,
    parameter int          ADDR_W     = 16,
    parameter int          DATA_W     = 16,
    parameter int unsigned BASE_ADDR  = 32'hFF10,
    parameter int          VEC_STRIDE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SRC-1:0]  irq_src,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              int_req,
    input  logic              int_ack,
    output logic [ADDR_W-1:0] int_vector,
    input  logic [ADDR_W-1:0] retaddr_in,
    input  logic              int_done
);

    localparam int ID_W = id_width(N_SRC);

    state_e            state_q;
    logic [N_SRC-1:0]  pending_q, pending_d;
    logic [N_SRC-1:0]  mask_q;
    logic [N_SRC:0]    ctrl_q;
    logic [DATA_W-1:0] vec_base_q;
    logic [DATA_W-1:0] retaddr_q, retaddr_d;
    logic [N_SRC-1:0]  prev_q;
    logic [ID_W-1:0]   id_q;
    logic              int_req_q;
    logic [ADDR_W-1:0] int_vector_q;
    logic [DATA_W-1:0] rdata_q;

    logic [ADDR_W-1:0] w_off;
    logic              w_hit;
    logic [2:0]        w_sel;
    logic              w_wr_pending, w_wr_mask, w_wr_ctrl, w_wr_vec, w_wr_ret;
    logic              w_en;
    logic [N_SRC-1:0]  w_mode, w_rise, w_clr, w_masked;
    logic              w_ack_take, w_win_live;
    logic [ID_W-1:0]   w_enc_id;
    logic              w_enc_valid;
    logic [ADDR_W-1:0] w_vec;
    logic [DATA_W-1:0] w_rdata;

    // Addresses below the base wrap to large offsets and fall outside the window.
    assign w_off = d_addr - ADDR_W'(BASE_ADDR);
    assign w_hit = (w_off < ADDR_W'(c_n_regs));
    assign w_sel = w_off[2:0];

    assign w_wr_pending = write & w_hit & (w_sel == 3'(c_off_pending));
    assign w_wr_mask    = write & w_hit & (w_sel == 3'(c_off_mask));
    assign w_wr_ctrl    = write & w_hit & (w_sel == 3'(c_off_ctrl));
    assign w_wr_vec     = write & w_hit & (w_sel == 3'(c_off_vec_base));
    assign w_wr_ret     = write & w_hit & (w_sel == 3'(c_off_retaddr));

    assign w_en       = ctrl_q[c_ctrl_en_bit];
    assign w_mode     = ctrl_q[N_SRC:c_ctrl_mode_lsb];
    assign w_rise     = irq_src & ~prev_q;
    assign w_masked   = pending_q & mask_q;
    assign w_ack_take = (state_q == ST_REQ) & int_ack;
    assign w_win_live = w_en & w_masked[id_q];

    prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .req_i   (w_masked),
        .id_o    (w_enc_id),
        .valid_o (w_enc_valid)
    );

    assign w_vec = ADDR_W'(vec_base_q) + ADDR_W'(w_enc_id) * ADDR_W'(VEC_STRIDE);

    // Edge bits: set beats clear. Level bits simply track the source.
    always_comb begin
        w_clr = w_wr_pending ? wdata[N_SRC-1:0] : '0;
        if (w_ack_take) begin
            w_clr = w_clr | (N_SRC'(1) << id_q);
        end
        pending_d = (w_mode & ((pending_q & ~w_clr) | w_rise)) | (~w_mode & irq_src);
    end

    always_comb begin
        retaddr_d = retaddr_q;
        if (w_ack_take) begin
            retaddr_d = DATA_W'(retaddr_in);
        end else if (w_wr_ret) begin
            retaddr_d = wdata;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_sel)
                3'(c_off_pending):  w_rdata = DATA_W'(pending_q);
                3'(c_off_mask):     w_rdata = DATA_W'(mask_q);
                3'(c_off_ctrl):     w_rdata = DATA_W'(ctrl_q);
                3'(c_off_vec_base): w_rdata = vec_base_q;
                3'(c_off_retaddr):  w_rdata = retaddr_q;
                default:            w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q  <= '0;
            mask_q     <= '0;
            ctrl_q     <= '0;
            vec_base_q <= '0;
            retaddr_q  <= '0;
            prev_q     <= '0;
            rdata_q    <= '0;
        end else begin
            pending_q <= pending_d;
            prev_q    <= irq_src;
            retaddr_q <= retaddr_d;
            if (w_wr_mask) mask_q     <= wdata[N_SRC-1:0];
            if (w_wr_ctrl) ctrl_q     <= wdata[N_SRC:0];
            if (w_wr_vec)  vec_base_q <= wdata;
            if (read)      rdata_q    <= w_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            id_q         <= '0;
            int_req_q    <= 1'b0;
            int_vector_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_en && w_enc_valid) begin
                        state_q      <= ST_REQ;
                        id_q         <= w_enc_id;
                        int_req_q    <= 1'b1;
                        int_vector_q <= w_vec;
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        state_q   <= ST_SERVICE;
                        int_req_q <= 1'b0;
                    end else if (!w_win_live) begin
                        state_q   <= ST_IDLE;
                        int_req_q <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (int_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    int_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign rdata      = rdata_q;
    assign int_req    = int_req_q;
    assign int_vector = int_vector_q;

endmodule

`default_nettype wire

// File: tb/tb_int_controller.sv
// ============================================================================
// tb_int_controller : directed scoreboard bench for int_controller
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_int_controller;

    localparam logic [15:0] c_base = 16'hFF10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  irq_src;
    logic        read, write;
    logic [15:0] d_addr, wdata, rdata;
    logic        int_req, int_ack, int_done;
    logic [15:0] int_vector, retaddr_in;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    int_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_src    (irq_src),
        .read       (read),
        .write      (write),
        .d_addr     (d_addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .int_req    (int_req),
        .int_ack    (int_ack),
        .int_vector (int_vector),
        .retaddr_in (retaddr_in),
        .int_done   (int_done)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sb_push(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [15:0] obs);
        exp_t e;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        write  = 1'b1;
        d_addr = a;
        wdata  = d;
        tick();
        write  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
        sb_push(tag, exp);
        read   = 1'b1;
        d_addr = a;
        tick();
        read   = 1'b0;
        sb_check(rdata);
    endtask

    task automatic wait_req(input string tag, input int max_cyc);
        for (int k = 0; k < max_cyc && int_req !== 1'b1; k++) tick();
        sb_push(tag, 16'h0001);
        sb_check({15'b0, int_req});
    endtask

    task automatic pulse_ack(input logic [15:0] ra);
        int_ack    = 1'b1;
        retaddr_in = ra;
        tick();
        int_ack    = 1'b0;
    endtask

    task automatic pulse_done();
        int_done = 1'b1;
        tick();
        int_done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq_src = '0; read = 1'b0; write = 1'b0;
        d_addr = '0; wdata = '0; int_ack = 1'b0; int_done = 1'b0; retaddr_in = '0;
        tick(2);
        sb_push("rst_req", 16'h0000);   sb_check({15'b0, int_req});
        sb_push("rst_vec", 16'h0000);   sb_check(int_vector);
        sb_push("rst_rdata", 16'h0000); sb_check(rdata);
        rst_n = 1'b1;
        tick();

        // Edge source 2 through REQ, ack and SERVICE
        wr(c_base + 16'd1, 16'h0004);
        wr(c_base + 16'd3, 16'h0100);
        wr(c_base + 16'd2, 16'h0009);
        irq_src[2] = 1'b1;
        sb_push("edge_req_early", 16'h0000);
        tick();
        sb_check({15'b0, int_req});
        sb_push("edge_req", 16'h0001);
        tick();
        sb_check({15'b0, int_req});
        sb_push("edge_vec", 16'h0108); sb_check(int_vector);
        rd("pend_in_req", c_base, 16'h0004);

        pulse_ack(16'h1234);
        sb_push("req_after_ack", 16'h0000); sb_check({15'b0, int_req});
        rd("pend_after_ack", c_base, 16'h0000);
        rd("retaddr_cap", c_base + 16'd4, 16'h1234);
        pulse_ack(16'h5555);
        rd("ack_in_service", c_base + 16'd4, 16'h1234);
        pulse_done();
        wr(c_base + 16'd4, 16'hBEEF);
        rd("retaddr_wr", c_base + 16'd4, 16'hBEEF);

        // Clear racing a new edge on source 1
        irq_src = '0;
        tick();
        wr(c_base + 16'd1, 16'h0000);
        wr(c_base + 16'd2, 16'h0007);
        irq_src[1] = 1'b1;
        wr(c_base, 16'h0002);
        rd("set_beats_clr", c_base, 16'h0002);
        wr(c_base, 16'h0002);
        rd("w1c", c_base, 16'h0000);

        // Level sources 0 and 3, priority then second request
        irq_src = '0;
        wr(c_base + 16'd2, 16'h0001);
        wr(c_base + 16'd1, 16'h0009);
        irq_src = 4'b1001;
        wait_req("lvl_req0", 8);
        sb_push("lvl_vec0", 16'h0100); sb_check(int_vector);
        pulse_ack(16'h0000);
        irq_src = 4'b1000;
        tick(2);
        rd("pend_in_service", c_base, 16'h0008);
        pulse_done();
        wait_req("lvl_req3", 8);
        sb_push("lvl_vec3", 16'h010C); sb_check(int_vector);
        irq_src = '0;
        tick(2);
        sb_push("req_withdrawn", 16'h0000); sb_check({15'b0, int_req});
        sb_push("vec_stable", 16'h010C);    sb_check(int_vector);

        // Out-of-window access
        wr(c_base + 16'd7, 16'hFFFF);
        wr(c_base - 16'd1, 16'hFFFF);
        rd("oow_read", c_base + 16'd7, 16'h0000);
        rd("oow_mask", c_base + 16'd1, 16'h0009);
        rd("oow_ctrl", c_base + 16'd2, 16'h0001);

        // Reset during SERVICE
        irq_src = 4'b0001;
        wait_req("svc_req", 8);
        pulse_ack(16'h4321);
        irq_src = '0;
        rst_n   = 1'b0;
        tick();
        sb_push("rst_svc_req", 16'h0000);   sb_check({15'b0, int_req});
        sb_push("rst_svc_vec", 16'h0000);   sb_check(int_vector);
        sb_push("rst_svc_rdata", 16'h0000); sb_check(rdata);
        rst_n = 1'b1;
        pulse_done();
        tick();
        sb_push("done_after_rst", 16'h0000); sb_check({15'b0, int_req});
        rd("rst_pending", c_base,          16'h0000);
        rd("rst_mask",    c_base + 16'd1,  16'h0000);
        rd("rst_ctrl",    c_base + 16'd2,  16'h0000);
        rd("rst_vecbase", c_base + 16'd3,  16'h0000);
        rd("rst_retaddr", c_base + 16'd4,  16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
